// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: field widths, receiver FSM encoding, address compare.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Receiver FSM, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } rx_state_t;

  // Address byte carries the 7-bit address in [7:1], R/W in [0]
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                      input logic [I2C_ADDR_W-1:0] slave_addr);
    return addr_byte[I2C_BYTE_W-1:1] == slave_addr;
  endfunction

endpackage

// File: rtl/i2c_fsm_transition_detect.sv
// Synchronises one raw I2C line and emits 1-cycle rise/fall pulses aligned with the synced level.
// Latency: level and pulses lag the raw line by 2 clk.
// Backpressure: none; free-running sampler. Resets to the idle-high bus level.
module i2c_fsm_transition_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_level = r_sync2;
  assign o_rise  = r_sync2 & ~r_prev;
  assign o_fall  = ~r_sync2 & r_prev;

endmodule

// File: rtl/i2c_rx_shifter.sv
// Serial-to-parallel byte shifter with 3-bit bit counter, MSB first.
// Latency: o_byte_done/o_data are combinational on the 8th shift_en (full byte incl. that bit).
// Backpressure: none; clear wins over shift and zeroes the bit count.
module i2c_rx_shifter
  import i2c_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift_en,
  input  logic                  i_clear,
  input  logic                  i_din,
  output logic                  o_byte_done,
  output logic [I2C_BYTE_W-1:0] o_data
);

  logic [I2C_BYTE_W-1:0] r_shift;
  logic [2:0]            r_bit_cnt;
  logic [I2C_BYTE_W-1:0] w_shift_nxt;

  assign w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], i_din};
  assign o_data      = w_shift_nxt;
  assign o_byte_done = i_shift_en && !i_clear && (r_bit_cnt == 3'd7);

  // Shift one bit in per enable; counter wraps 7->0 at the byte boundary
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= 3'd0;
    end else if (i_shift_en) begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/i2c_slave_byte_receiver.sv
// I2C slave write path: START/STOP decode, address match, byte assembly, ACK pull-down.
// Latency: 1 clk after the incoming edge pulses (all outputs registered).
// Backpressure: none; bus-paced. START/STOP override any SCL pulse in the same cycle.
module i2c_slave_byte_receiver
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       sda_rise,
  input  logic       sda_fall,
  output logic       sda_drive_low,
  output logic       start_det,
  output logic       stop_det,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_is_addr,
  output logic       rw_bit,
  output logic       busy
);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic                  r_drive;
  logic                  w_drive_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_rw;
  logic                  w_rw_nxt;
  // Byte complete and ACK owed: waiting for SCL low before pulling SDA
  logic                  r_ack_pend;
  logic                  w_ack_pend_nxt;

  logic                  r_start_det;
  logic                  r_stop_det;
  logic [I2C_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_is_addr;

  logic                  w_start;
  logic                  w_stop;
  logic                  w_event;
  logic                  w_shift_en;
  logic                  w_byte_done;
  logic [I2C_BYTE_W-1:0] w_byte;

  assign w_start = sda_fall && scl_in;
  assign w_stop  = sda_rise && scl_in;
  assign w_event = w_start || w_stop;

  // Sample data bits only while receiving and not sitting on a pending ACK
  assign w_shift_en = scl_rise && !w_event && !r_ack_pend &&
                      ((r_state == ST_ADDR) || (r_state == ST_DATA));

  i2c_rx_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_shift_en  (w_shift_en),
    .i_clear     (w_event),
    .i_din       (sda_in),
    .o_byte_done (w_byte_done),
    .o_data      (w_byte)
  );

  // FSM and control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_drive    <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_ack_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_drive    <= w_drive_nxt;
      r_busy     <= w_busy_nxt;
      r_rw       <= w_rw_nxt;
      r_ack_pend <= w_ack_pend_nxt;
    end
  end

  // Next-state logic; SDA drive only changes on SCL fall, START or STOP
  always_comb begin
    w_state_nxt    = r_state;
    w_drive_nxt    = r_drive;
    w_busy_nxt     = r_busy;
    w_rw_nxt       = r_rw;
    w_ack_pend_nxt = r_ack_pend;
    if (w_start) begin
      w_state_nxt    = ST_ADDR;
      w_drive_nxt    = 1'b0;
      w_busy_nxt     = 1'b1;
      w_ack_pend_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt    = ST_IDLE;
      w_drive_nxt    = 1'b0;
      w_busy_nxt     = 1'b0;
      w_ack_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_byte_done) begin
            if (addr_match(w_byte, SLAVE_ADDR)) begin
              w_rw_nxt       = w_byte[0];
              w_ack_pend_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else if (r_ack_pend && scl_fall) begin
            w_drive_nxt    = 1'b1;
            w_ack_pend_nxt = 1'b0;
            w_state_nxt    = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            w_drive_nxt = 1'b0;
            w_state_nxt = r_rw ? ST_IGNORE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            w_ack_pend_nxt = 1'b1;
          end else if (r_ack_pend && scl_fall) begin
            w_drive_nxt    = 1'b1;
            w_ack_pend_nxt = 1'b0;
            w_state_nxt    = ST_DATA_ACK;
          end
        end
        ST_DATA_ACK: begin
          if (scl_fall) begin
            w_drive_nxt = 1'b0;
            w_state_nxt = ST_DATA;
          end
        end
        default: begin
          // IDLE and IGNORE wait for START/STOP only
        end
      endcase
    end
  end

  // Registered event pulses and received-byte outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_is_addr <= 1'b0;
    end else begin
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
      r_rx_valid  <= w_byte_done;
      if (w_byte_done) begin
        r_rx_data    <= w_byte;
        r_rx_is_addr <= (r_state == ST_ADDR);
      end
    end
  end

  assign sda_drive_low = r_drive;
  assign start_det     = r_start_det;
  assign stop_det      = r_stop_det;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_is_addr    = r_rx_is_addr;
  assign rw_bit        = r_rw;
  assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_slave_byte_receiver.sv
// Bit-bangs an I2C master through two transition detectors into the receiver.
// Received bytes are scored against a queue filled as bytes are driven.
// ACK drive, event counts and busy are checked inline.
module tb_i2c_slave_byte_receiver;

  logic       clk;
  logic       rst;
  logic       tb_scl;
  logic       tb_sda;
  logic       sda_bus;

  logic       scl_lvl, scl_rise, scl_fall;
  logic       sda_lvl, sda_rise, sda_fall;
  logic       sda_drive_low, start_det, stop_det, rx_valid, rx_is_addr, rw_bit, busy;
  logic [7:0] rx_data;

  int n_checks;
  int n_errors;
  int start_cnt;
  int stop_cnt;
  logic drive_seen;
  logic [8:0] sb_q[$];

  assign sda_bus = tb_sda & ~sda_drive_low;

  i2c_fsm_transition_detect u_scl_det (
    .clk(clk), .rst(rst), .i_line(tb_scl),
    .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  i2c_fsm_transition_detect u_sda_det (
    .clk(clk), .rst(rst), .i_line(sda_bus),
    .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  i2c_slave_byte_receiver #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst),
    .scl_in(scl_lvl), .sda_in(sda_lvl),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .sda_rise(sda_rise), .sda_fall(sda_fall),
    .sda_drive_low(sda_drive_low),
    .start_det(start_det), .stop_det(stop_det),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_is_addr(rx_is_addr),
    .rw_bit(rw_bit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor on the falling edge: score bytes, count events
  always @(negedge clk) begin
    if (!rst) begin
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_drive_low) drive_seen = 1'b1;
      if (rx_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("rx_unexpected_qsize", sb_q.size(), 1);
        end else begin
          check_eq("rx_byte", {23'd0, rx_is_addr, rx_data}, {23'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    tb_sda = 1'b0; wait_clk(4);
    tb_scl = 1'b0; wait_clk(4);
  endtask

  task automatic bus_restart();
    tb_sda = 1'b1; wait_clk(4);
    tb_scl = 1'b1; wait_clk(4);
    bus_start();
  endtask

  task automatic bus_stop();
    tb_sda = 1'b0; wait_clk(4);
    tb_scl = 1'b1; wait_clk(4);
    tb_sda = 1'b1; wait_clk(6);
  endtask

  task automatic send_bit(input logic b);
    tb_sda = b;    wait_clk(4);
    tb_scl = 1'b1; wait_clk(4);
    tb_scl = 1'b0; wait_clk(4);
  endtask

  // Eight data bits plus the ACK clock; checks slave drive in ACK high and after release
  task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                           input logic is_addr, input logic exp_rx, input string tag);
    if (exp_rx) sb_q.push_back({is_addr, b});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tb_sda = 1'b1; wait_clk(4);
    tb_scl = 1'b1; wait_clk(4);
    check_eq({tag, "_ack"}, sda_drive_low, exp_ack);
    tb_scl = 1'b0; wait_clk(4);
    check_eq({tag, "_rel"}, sda_drive_low, 0);
  endtask

  int s0, p0;

  initial begin
    n_checks = 0; n_errors = 0; start_cnt = 0; stop_cnt = 0; drive_seen = 1'b0;
    tb_scl = 1'b1; tb_sda = 1'b1; rst = 1'b1;
    wait_clk(3);
    check_eq("rst_drive", sda_drive_low, 0);
    check_eq("rst_start", start_det, 0);
    check_eq("rst_stop", stop_det, 0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rw", rw_bit, 0);
    rst = 1'b0;
    wait_clk(4);

    // 1: basic write
    s0 = start_cnt; p0 = stop_cnt;
    bus_start();
    check_eq("t1_busy_on", busy, 1);
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t1_addr");
    send_byte(8'h3C, 1'b1, 1'b0, 1'b1, "t1_data");
    bus_stop();
    check_eq("t1_starts", start_cnt - s0, 1);
    check_eq("t1_stops", stop_cnt - p0, 1);
    check_eq("t1_busy_off", busy, 0);
    check_eq("t1_rw", rw_bit, 0);

    // 2: address mismatch, never drives SDA
    drive_seen = 1'b0;
    bus_start();
    send_byte(8'hA2, 1'b0, 1'b1, 1'b1, "t2_addr");
    send_byte(8'h55, 1'b0, 1'b0, 1'b0, "t2_ign");
    bus_stop();
    check_eq("t2_drive_seen", drive_seen, 0);
    check_eq("t2_busy_off", busy, 0);

    // 3: repeated START into a read address
    s0 = start_cnt;
    bus_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t3_addr_w");
    send_byte(8'h11, 1'b1, 1'b0, 1'b1, "t3_data");
    bus_restart();
    send_byte(8'hA1, 1'b1, 1'b1, 1'b1, "t3_addr_r");
    check_eq("t3_rw", rw_bit, 1);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0, "t3_ign");
    check_eq("t3_starts", start_cnt - s0, 2);
    bus_stop();

    // 4: STOP mid-byte discards the partial byte
    p0 = stop_cnt;
    bus_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t4_addr");
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bus_stop();
    check_eq("t4_stops", stop_cnt - p0, 1);
    check_eq("t4_busy_off", busy, 0);
    check_eq("t4_drive", sda_drive_low, 0);

    // 5: reset while the slave holds the data ACK
    bus_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t5_addr");
    sb_q.push_back({1'b0, 8'h5A});
    for (int i = 7; i >= 0; i--) send_bit(8'h5A >> i);
    tb_sda = 1'b1; wait_clk(4);
    tb_scl = 1'b1; wait_clk(4);
    check_eq("t5_ack_before_rst", sda_drive_low, 1);
    rst = 1'b1; wait_clk(1);
    rst = 1'b0;
    check_eq("t5_drive_after_rst", sda_drive_low, 0);
    check_eq("t5_busy_after_rst", busy, 0);
    check_eq("t5_rx_data_after_rst", rx_data, 8'h00);
    wait_clk(4);
    tb_scl = 1'b0; wait_clk(4);
    bus_stop();
    bus_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t5_addr2");
    send_byte(8'hC3, 1'b1, 1'b0, 1'b1, "t5_data2");
    bus_stop();

    // 6: back-to-back bytes, counter wraps each byte
    bus_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b1, "t6_addr");
    send_byte(8'hFF, 1'b1, 1'b0, 1'b1, "t6_ff");
    send_byte(8'h00, 1'b1, 1'b0, 1'b1, "t6_00");
    send_byte(8'h80, 1'b1, 1'b0, 1'b1, "t6_80");
    bus_stop();
    check_eq("t6_busy_off", busy, 0);

    wait_clk(4);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
